// File: rtl/arb_rr_4_1.sv
// arb_rr_4_1: round-robin arbiter sharing one downstream valid/ready port
// among four requesters. A grant is held for a whole transaction, up to and
// including the beat with last=1. One idle cycle separates transactions.
// Optional per-requester grant counters are compiled in with the macro
// ARB_PERF_CNT_EN (adds parameter CNT_W and output grant_cnt).
module arb_rr_4_1 #(
    parameter int DATA_LEN = 32
`ifdef ARB_PERF_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            in_valid,
    input  logic [3:0]            in_last,
    input  logic [4*DATA_LEN-1:0] in_data,
    output logic [3:0]            in_ready,
    output logic                  out_valid,
    output logic                  out_last,
    output logic [DATA_LEN-1:0]   out_data,
    input  logic                  out_ready,
    output logic [1:0]            gnt_sel,
    output logic [3:0]            gnt_oh,
    output logic                  busy
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [4*CNT_W-1:0]    grant_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_sel_q, gnt_sel_d;
    logic [3:0] gnt_oh_q, gnt_oh_d;

    logic [1:0] cand;
    logic [1:0] pick_idx;
    logic       pick_vld;
    logic       done;

    // Rotating priority scan: first requesting index starting at ptr.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cand     = '0;
        pick_idx = ptr_q;
        pick_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!pick_vld && in_valid[cand]) begin
                pick_idx = cand;
                pick_vld = 1'b1;
            end
        end
    end

    // Final beat of the granted transaction is accepted downstream.
    assign done = (state_q == BUSY) && in_valid[gnt_sel_q] && in_last[gnt_sel_q] && out_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q <= state_d;
        end
    end

    // Next-state logic: grant on any request, release on the last handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_vld) state_d = BUSY;
            BUSY:    if (done)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Grant bookkeeping: latch the winner on grant, advance ptr on completion.
    always_comb begin
        ptr_d     = ptr_q;
        gnt_sel_d = gnt_sel_q;
        gnt_oh_d  = gnt_oh_q;
        if (state_q == IDLE && pick_vld) begin
            gnt_sel_d = pick_idx;
            gnt_oh_d  = 4'b0001 << pick_idx;
        end
        if (done) begin
            ptr_d    = gnt_sel_q + 2'd1;
            gnt_oh_d = 4'b0000;
        end
    end

    // Grant registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= 2'd0;
            gnt_sel_q <= 2'd0;
            gnt_oh_q  <= 4'b0000;
        end else begin
            ptr_q     <= ptr_d;
            gnt_sel_q <= gnt_sel_d;
            gnt_oh_q  <= gnt_oh_d;
        end
    end

    // Output logic: route only the granted requester; nothing passes while idle.
    always_comb begin
        busy      = (state_q == BUSY);
        gnt_sel   = gnt_sel_q;
        gnt_oh    = gnt_oh_q;
        out_data  = in_data[int'(gnt_sel_q)*DATA_LEN +: DATA_LEN];
        out_valid = busy & in_valid[gnt_sel_q];
        out_last  = busy & in_last[gnt_sel_q];
        in_ready  = (busy && out_ready) ? gnt_oh_q : 4'b0000;
    end

`ifdef ARB_PERF_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Saturating count of grants issued to each requester.
    always_comb begin
        for (int i = 0; i < 4; i++) cnt_d[i] = cnt_q[i];
        if (state_q == IDLE && pick_vld && cnt_q[pick_idx] != {CNT_W{1'b1}}) begin
            cnt_d[pick_idx] = cnt_q[pick_idx] + 1'b1;
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Flatten the counters onto the output bus.
    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < 4; i++) grant_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
`endif

endmodule

// File: doc/arb_rr_4_1.md
Name: arb_rr_4_1

Overview:
- Round-robin arbiter/controller that shares one downstream port among 4 requesters, e.g. IFU/LSU/debug ports onto one memory bus in the NPC.
- Owns the select of the 4:1 data mux. Routes the valid/ready handshake of the granted requester only.
- Holds the grant for a whole multi-beat transaction, up to and including the beat with last=1.

Parameters:
DATA_LEN, 32, width of each requester's data beat
CNT_W, 16, width of each per-requester grant counter (optional feature only)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  4  per-requester beat valid, bit i = requester i
in_last  input  4  per-requester last-beat flag, qualified by in_valid
in_data  input  4*DATA_LEN  requester i occupies bits [i*DATA_LEN +: DATA_LEN]
in_ready  output  4  per-requester ready; only the granted bit can be 1
out_valid  output  1  downstream beat valid
out_last  output  1  downstream last-beat flag
out_data  output  DATA_LEN  muxed data of the granted requester
out_ready  input  1  downstream ready
gnt_sel  output  2  index of the granted requester (mux select)
gnt_oh  output  4  one-hot grant; 0 when idle
busy  output  1  1 while a grant is held
grant_cnt  output  4*CNT_W  present only with ARB_PERF_CNT_EN

Behaviour:
- Reset (async assert, sync deassert by the system):
  - state=IDLE, ptr=0, gnt_sel=0, gnt_oh=0, busy=0.
  - out_valid=0, in_ready=0; out_data and out_last are don't-care but driven as requester 0 passthrough gated.
- States: IDLE, BUSY.
- IDLE:
  - out_valid=0, in_ready=0.
  - If any in_valid bit is set, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Register it into gnt_sel and gnt_oh; next state BUSY.
  - If no bit is set, stay in IDLE.
  - Grant latency: 1 cycle from in_valid to out_valid.
- BUSY (granted index g):
  - out_valid=in_valid[g], out_last=in_last[g], out_data=in_data[g].
  - in_ready[g]=out_ready; all other in_ready bits are 0.
  - Beat handshake = out_valid & out_ready.
  - On a handshake with out_last=1: ptr <= g+1 (2-bit wrap, 3 -> 0), gnt_oh <= 0, next state IDLE.
  - A handshake with out_last=0 keeps the grant.
- Bubble: each arbitration costs exactly one idle cycle between transactions (no back-to-back regrant). Peak transaction rate is 1 beat per cycle within a burst.
- Requester g dropping in_valid mid-burst: grant is held indefinitely; out_valid follows in_valid[g]. Other requesters remain stalled (no preemption).
- ptr advances only on completion of a transaction, never on a mere grant.
- Fairness: a continuously requesting requester waits at most 3 transactions.
- Requests arriving on the completion cycle are considered in the following IDLE cycle, using the updated ptr.
- Reset asserted mid-burst: immediate return to the reset values. The beat in flight is dropped; the downstream side must tolerate an unterminated burst on reset.
- No combinational path from in_valid to in_ready. The only combinational paths are out_ready -> in_ready and the in_* -> out_* data/valid/last.

Optional Feature:
- Macro: ARB_PERF_CNT_EN.
- Defined:
  - Adds output grant_cnt and four CNT_W-bit counters; counter i is at bits [i*CNT_W +: CNT_W].
  - Counter i increments by 1 on each IDLE -> BUSY transition granting i.
  - Counters saturate at all-ones (no wrap) and reset to 0 on rst_n.
- Not defined: no counters, no grant_cnt port; all other behaviour is identical.

Test Plan:
- Single requester: in_valid=4'b0100, in_last=1, in_data[2]=32'hDEAD_BEEF, out_ready=1.
  -> Cycle 1: gnt_sel=2, gnt_oh=4'b0100, out_valid=1, out_data=32'hDEAD_BEEF, in_ready=4'b0100.
  -> Cycle 2: IDLE, busy=0.
- All four requesting with single-beat transactions, out_ready=1 -> grant order 0,1,2,3,0; one idle cycle between grants.
- Burst lock: requester 1 sends 3 beats (last on the 3rd) while requester 0 requests.
  -> gnt_sel stays 1 for all 3 handshakes, in_ready[0]=0 throughout.
  -> Requester 0 is granted after the IDLE cycle.
- Backpressure: granted requester 3, out_ready=0 for 5 cycles.
  -> in_ready=0 and out_valid=1 are held with stable out_data.
  -> The beat completes on the first cycle out_ready=1.
- Reset mid-burst: rst_n=0 during beat 2 of 4.
  -> Same cycle: out_valid=0, gnt_oh=0, busy=0.
  -> After release with all requesting: grant goes to 0 (ptr=0).
- ARB_PERF_CNT_EN, CNT_W=2: requester 2 completes 5 single-beat transactions.
  -> grant_cnt[2] reads 1,2,3,3,3; the other counters stay 0.
